// File: rtl/rotor_stage.sv
// -----------------------------------------------------------------------------
// rotor_stage
//
// Programmable, steppable substitution rotor. Holds an N-entry wiring
// permutation (fwd) and maintains its inverse (inv) on every config write.
// Each valid input character is shifted by (pos - ring), passed through the
// forward or inverse table, and shifted back by (ring - pos). The result is
// registered, so lookup latency is one cycle at one character per cycle.
// carry_out pulses for one cycle after a step taken at the NOTCH position.
// It is sized to drive the next stage's step input directly.
//
// Parameters:
//   N      alphabet size (2..2^W)
//   W      character/index width (2^W >= N)
//   NOTCH  position whose step produces a turnover carry (0..N-1)
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset, overrides all other inputs
//   cfg_we     write one wiring entry: fwd[cfg_addr] = cfg_data
//   cfg_addr   wiring input index
//   cfg_data   wiring output value
//   pos_load   load position from pos_in (priority over step)
//   pos_in     new position
//   ring_load  load ring setting from ring_in
//   ring_in    new ring setting
//   step       advance position by one, modulo N
//   in_valid   input character present
//   in_dir     0 = forward table, 1 = inverse table
//   in_char    input character
//   out_valid  mapped character present
//   out_char   mapped character (all ones on range error, holds when idle)
//   out_err    input character was out of range
//   carry_out  one-cycle turnover pulse
//   pos_out    current position
// -----------------------------------------------------------------------------
module rotor_stage #(
    parameter int N     = 26,
    parameter int W     = 5,
    parameter int NOTCH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         pos_load,
    input  logic [W-1:0] pos_in,
    input  logic         ring_load,
    input  logic [W-1:0] ring_in,
    input  logic         step,
    input  logic         in_valid,
    input  logic         in_dir,
    input  logic [W-1:0] in_char,
    output logic         out_valid,
    output logic [W-1:0] out_char,
    output logic         out_err,
    output logic         carry_out,
    output logic [W-1:0] pos_out
);

    localparam logic [W:0]   N_EXT   = (W+1)'(N);
    localparam logic [W-1:0] NOTCH_W = W'(NOTCH);
    localparam logic [W-1:0] LAST_W  = W'(N - 1);

    // (a + b) mod N for a, b < N: one W+1-bit add, one conditional subtract.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        return sum[W-1:0];
    endfunction

    // (a - b) mod N for a, b < N: add N first so the W+1-bit value never
    // goes negative, then one conditional subtract.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] diff;
        diff = {1'b0, a} + N_EXT - {1'b0, b};
        if (diff >= N_EXT) begin
            diff = diff - N_EXT;
        end
        return diff[W-1:0];
    endfunction

    // ---------------------------------------------------------------- state
    logic [W-1:0] fwd_q [N];
    logic [W-1:0] inv_q [N];
    logic [W-1:0] pos_q,  pos_d;
    logic [W-1:0] ring_q, ring_d;
    logic         carry_q, carry_d;
    logic         out_valid_q, out_valid_d;
    logic         out_err_q,   out_err_d;
    logic [W-1:0] out_char_q,  out_char_d;

    // ------------------------------------------------------ range qualifiers
    logic in_ok, cfg_ok, pos_ok, ring_ok;

    assign in_ok   = {1'b0, in_char} < N_EXT;
    assign cfg_ok  = ({1'b0, cfg_addr} < N_EXT) && ({1'b0, cfg_data} < N_EXT);
    assign pos_ok  = {1'b0, pos_in}  < N_EXT;
    assign ring_ok = {1'b0, ring_in} < N_EXT;

    // ------------------------------------------------------------- datapath
    // Out-of-range characters are forced to 0 before indexing so the table
    // read never addresses past entry N-1; the result is discarded anyway.
    logic [W-1:0] char_safe;
    logic [W-1:0] s_idx;
    logic [W-1:0] m_val;
    logic [W-1:0] mapped;

    always_comb begin
        char_safe = in_ok ? in_char : '0;
        s_idx     = mod_sub(mod_add(char_safe, pos_q), ring_q);
        m_val     = in_dir ? inv_q[s_idx] : fwd_q[s_idx];
        mapped    = mod_add(mod_sub(m_val, pos_q), ring_q);
    end

    // ------------------------------------------------------- next-state logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the value.
        pos_d       = pos_q;
        carry_d     = 1'b0;
        ring_d      = ring_q;
        out_valid_d = in_valid;
        out_err_d   = in_valid && !in_ok;
        out_char_d  = out_char_q;

        // A load blocks the step even when pos_in is rejected, and a load
        // never produces a carry.
        if (pos_load) begin
            if (pos_ok) begin
                pos_d = pos_in;
            end
        end else if (step) begin
            carry_d = (pos_q == NOTCH_W);
            pos_d   = (pos_q == LAST_W) ? '0 : pos_q + W'(1);
        end

        if (ring_load && ring_ok) begin
            ring_d = ring_in;
        end

        if (in_valid) begin
            out_char_d = in_ok ? mapped : '1;
        end
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; that is what lets a lookup in the same cycle
    // as a step/load/config write see the old pos, ring and tables.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wiring tables are reset, unlike a typical RAM,
            // because identity wiring is an architectural reset state; this
            // forces them into flops rather than a memory macro.
            for (int i = 0; i < N; i++) begin
                fwd_q[i] <= W'(i);
                inv_q[i] <= W'(i);
            end
            pos_q       <= '0;
            ring_q      <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_char_q  <= '0;
        end else begin
            // The inverse is kept in step with the forward table; it is only
            // self-consistent once a full permutation has been written.
            if (cfg_we && cfg_ok) begin
                fwd_q[cfg_addr] <= cfg_data;
                inv_q[cfg_data] <= cfg_addr;
            end
            pos_q       <= pos_d;
            ring_q      <= ring_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_char_q  <= out_char_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_err   = out_err_q;
    assign carry_out = carry_q;
    assign pos_out   = pos_q;

endmodule

// File: tb/tb_rotor_stage.sv
// -----------------------------------------------------------------------------
// tb_rotor_stage
//
// Scoreboard bench for rotor_stage. The driver applies stimulus just after a
// rising edge; at the next rising edge it runs a behavioural model (integer
// modulo arithmetic, reverse lookups by searching the forward table) and
// pushes the expected response into a queue. An independent monitor on the
// falling edge pops and compares whenever an output is due, and also checks
// pos_out, carry_out and the hold behaviour of out_char every cycle.
// -----------------------------------------------------------------------------
module tb_rotor_stage;

    localparam int N     = 26;
    localparam int W     = 5;
    localparam int NOTCH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_we = 1'b0;
    logic [W-1:0] cfg_addr = '0;
    logic [W-1:0] cfg_data = '0;
    logic         pos_load = 1'b0;
    logic [W-1:0] pos_in = '0;
    logic         ring_load = 1'b0;
    logic [W-1:0] ring_in = '0;
    logic         step = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_dir = 1'b0;
    logic [W-1:0] in_char = '0;
    logic         out_valid;
    logic [W-1:0] out_char;
    logic         out_err;
    logic         carry_out;
    logic [W-1:0] pos_out;

    always #5 clk = ~clk;

    rotor_stage #(.N(N), .W(W), .NOTCH(NOTCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .pos_load  (pos_load),
        .pos_in    (pos_in),
        .ring_load (ring_load),
        .ring_in   (ring_in),
        .step      (step),
        .in_valid  (in_valid),
        .in_dir    (in_dir),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_err   (out_err),
        .carry_out (carry_out),
        .pos_out   (pos_out)
    );

    // ------------------------------------------------------------ bookkeeping
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------- the model
    typedef struct {
        bit err;
        int ch;
    } exp_t;

    exp_t sb_q[$];
    int   m_fwd[N];
    int   m_pos = 0;
    int   m_ring = 0;
    int   exp_carry = 0;
    int   last_char = 0;
    int   exp_override = -1;   // directed tests may supply the expected char
    bit   mon_en = 1'b0;

    // Evaluated at a rising edge with the inputs the DUT just sampled.
    task automatic model_edge();
        exp_t e;
        int   c, s, m;
        if (rst) begin
            for (int i = 0; i < N; i++) m_fwd[i] = i;
            m_pos     = 0;
            m_ring    = 0;
            exp_carry = 0;
            last_char = 0;
            sb_q.delete();
            return;
        end
        // Lookup against pre-edge state.
        if (in_valid) begin
            c = int'(in_char);
            if (c >= N) begin
                e.err = 1'b1;
                e.ch  = (1 << W) - 1;
            end else begin
                s = (c + m_pos - m_ring + N) % N;
                if (!in_dir) begin
                    m = m_fwd[s];
                end else begin
                    m = -1;
                    for (int j = 0; j < N; j++) if (m_fwd[j] == s) m = j;
                end
                e.err = 1'b0;
                e.ch  = (m - m_pos + m_ring + N) % N;
                if (exp_override >= 0) e.ch = exp_override;
            end
            sb_q.push_back(e);
        end
        // State updates.
        if (cfg_we && int'(cfg_addr) < N && int'(cfg_data) < N)
            m_fwd[int'(cfg_addr)] = int'(cfg_data);
        exp_carry = 0;
        if (pos_load) begin
            if (int'(pos_in) < N) m_pos = int'(pos_in);
        end else if (step) begin
            exp_carry = (m_pos == NOTCH) ? 1 : 0;
            m_pos     = (m_pos + 1) % N;
        end
        if (ring_load && int'(ring_in) < N) m_ring = int'(ring_in);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            check("out_valid", {31'b0, out_valid}, (sb_q.size() > 0) ? 1 : 0);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_err", {31'b0, out_err}, e.err ? 1 : 0);
                check("out_char", {27'b0, out_char}, e.ch);
                last_char = e.ch;
            end else begin
                check("out_err_idle", {31'b0, out_err}, 0);
                check("out_char_hold", {27'b0, out_char}, last_char);
            end
            check("pos_out", {27'b0, pos_out}, m_pos);
            check("carry_out", {31'b0, carry_out}, exp_carry);
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        rst          = 1'b0;
        cfg_we       = 1'b0;
        pos_load     = 1'b0;
        ring_load    = 1'b0;
        step         = 1'b0;
        in_valid     = 1'b0;
        exp_override = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
    endtask

    task automatic cfg(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = W'(a);
        cfg_data = W'(d);
        cycle();
    endtask

    task automatic load_pos(input int p);
        pos_load = 1'b1;
        pos_in   = W'(p);
        cycle();
    endtask

    task automatic load_ring(input int r);
        ring_load = 1'b1;
        ring_in   = W'(r);
        cycle();
    endtask

    task automatic do_step();
        step = 1'b1;
        cycle();
    endtask

    task automatic lookup(input bit dir, input int ch, input int ovr);
        in_valid     = 1'b1;
        in_dir       = dir;
        in_char      = W'(ch);
        exp_override = ovr;
        cycle();
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin : stim
        int perm[N];
        int tmp, j;

        do_reset();
        mon_en = 1'b1;
        cycle();

        // Identity pass-through with offsets applied.
        load_pos(7);
        load_ring(3);
        for (int c = 0; c < N; c++) lookup(1'b0, c, c);
        for (int c = 0; c < N; c++) lookup(1'b1, c, c);
        cycle();

        // Swap-entry offset check.
        cfg(0, 4);
        cfg(4, 0);
        load_pos(1);
        load_ring(0);
        lookup(1'b0, 25, 3);
        lookup(1'b1, 3, 25);
        lookup(1'b0, 0, 0);

        // Step together with a lookup: old position used, pos_out 2 after.
        step = 1'b1;
        lookup(1'b0, 25, 3);
        cycle();

        // Stepping and turnover.
        load_pos(24);
        repeat (3) do_step();
        load_pos(16);
        do_step();
        cycle();
        load_pos(16);
        pos_load = 1'b1;
        pos_in   = W'(16);
        step     = 1'b1;
        cycle();
        cycle();

        // Range rejection.
        lookup(1'b0, 27, -1);
        lookup(1'b1, 31, -1);
        cfg(26, 9);
        cfg(3, 30);
        load_pos(30);
        load_ring(5);
        load_ring(26);
        for (int c = 0; c < 6; c++) lookup(c[0], c, -1);

        // Reset mid-stream on the fifth character.
        for (int k = 0; k < 10; k++) begin
            if (k == 4) rst = 1'b1;
            lookup(k[0], k + 2, -1);
        end
        for (int c = 0; c < N; c++) lookup(1'b1, c, c);
        cycle();

        // Randomized: full random permutations, then random traffic.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) perm[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                j       = int'($urandom_range(i, 0));
                tmp     = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            for (int i = 0; i < N; i++) cfg(i, perm[i]);
            load_pos(int'($urandom_range(N - 1, 0)));
            load_ring(int'($urandom_range(N - 1, 0)));
            for (int c = 0; c < 300; c++) begin
                in_valid  = ($urandom_range(3, 0) != 0);
                in_dir    = 1'($urandom_range(1, 0));
                in_char   = ($urandom_range(15, 0) == 0) ? W'($urandom_range(31, N))
                                                         : W'($urandom_range(N - 1, 0));
                step      = ($urandom_range(2, 0) == 0);
                pos_load  = ($urandom_range(15, 0) == 0);
                pos_in    = W'($urandom_range(31, 0));
                ring_load = ($urandom_range(15, 0) == 0);
                ring_in   = W'($urandom_range(31, 0));
                // Only rejected writes here, so the table stays a permutation.
                cfg_we    = ($urandom_range(7, 0) == 0);
                if ($urandom_range(1, 0) == 0) begin
                    cfg_addr = W'($urandom_range(31, N));
                    cfg_data = W'($urandom_range(31, 0));
                end else begin
                    cfg_addr = W'($urandom_range(N - 1, 0));
                    cfg_data = W'($urandom_range(31, N));
                end
                rst = ($urandom_range(199, 0) == 0);
                cycle();
            end
        end

        repeat (3) cycle();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotor_stage.md
# rotor_stage

Programmable, steppable substitution rotor for the cipher datapath. It holds a loadable N-entry permutation and keeps its inverse automatically. It applies position and ring-setting offsets, and maps one character per cycle in either direction with a registered output. The rotor stack controller instantiates one per rotor and chains `carry_out` into the next stage's `step`.

## Interface
- `N`, 26, alphabet size (2..2^W)
- `W`, 5, character/index width; must satisfy 2^W ≥ N
- `NOTCH`, 16, position at which stepping produces a turnover carry (0..N-1)

Ports (reset is synchronous and active-high):
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous active-high reset
- `cfg_we` in 1: write one wiring entry
- `cfg_addr` in W: wiring input index
- `cfg_data` in W: wiring output value
- `pos_load` in 1: load position
- `pos_in` in W: new position
- `ring_load` in 1: load ring setting
- `ring_in` in W: new ring setting
- `step` in 1: advance position by one
- `in_valid` in 1: character present
- `in_dir` in 1: 0 = forward (table), 1 = reverse (inverse table)
- `in_char` in W: input character
- `out_valid` out 1: mapped character present
- `out_char` out W: mapped character
- `out_err` out 1: input was out of range
- `carry_out` out 1: turnover pulse
- `pos_out` out W: current position

## Operation
- **State:** `fwd[N]`, `inv[N]` (W bits each), `pos`, `ring`, output registers.
- **Reset values:**
  - `fwd[i]` = `inv[i]` = i (identity).
  - `pos` = `ring` = 0.
  - `out_valid` = `out_err` = `carry_out` = 0; `out_char` = 0; `pos_out` = 0.
- **Config write:** when `cfg_we` is high and both `cfg_addr` and `cfg_data` are < N, `fwd[cfg_addr]` ← `cfg_data` and `inv[cfg_data]` ← `cfg_addr`.
  - A write with either field ≥ N is ignored.
  - Consistency of `inv` is guaranteed only after a full permutation has been written. Partial tables are undefined for reverse lookups.
- **Position:**
  - `pos_load` has priority over `step`. The load takes `pos_in` only if it is < N; otherwise `pos` is unchanged. A load never produces a carry.
  - On `step` without `pos_load`: `pos` ← (`pos`+1) mod N, wrapping from N-1 to 0.
  - If `pos` == `NOTCH` at that edge, `carry_out` is 1 on the next cycle; otherwise it is 0.
- **Ring:** on `ring_load` with `ring_in` < N, `ring` ← `ring_in`; values ≥ N are ignored.
- **Datapath,** for `in_valid` with `in_char` < N:
  - s = (`in_char` + `pos` − `ring`) mod N
  - m = `fwd[s]` if `in_dir` = 0, else `inv[s]`
  - `out_char` = (m − `pos` + `ring`) mod N
  - Compute with W+1-bit intermediates, adding N before a subtraction to stay non-negative, then apply a single conditional subtract of N.
- **Out-of-range input:** `in_valid` with `in_char` ≥ N gives `out_err` = 1 and `out_char` = 2^W−1 (all ones).
- **No input:** with `in_valid` = 0, `out_valid` = 0 and `out_err` = 0. `out_char` holds its last value.
- **Simultaneous events:** a lookup in the same cycle as `step`, `pos_load`, `ring_load` or `cfg_we` uses the pre-edge `pos`, `ring` and tables. The new values apply from the following cycle.
- **Reset mid-operation:** `rst` overrides every other input. Any in-flight output is dropped, so `out_valid` = 0 the cycle after reset.

## Timing
- Lookup latency is 1 cycle: `in_valid` at edge k gives `out_valid`/`out_char`/`out_err` valid after edge k.
- Throughput is 1 character/cycle. There is no backpressure; downstream must accept every `out_valid`.
- `pos_out` is registered `pos` and updates 1 cycle after `step`/`pos_load`.
- `carry_out` is a one-cycle pulse, registered, 1 cycle after the turnover step. It is level-correct for direct connection to the next stage's `step`.
- Config, position and ring writes take effect 1 cycle after their edge.

## Test plan
- **Reset then identity pass-through:** apply `rst`, then in 0..25 fwd and rev with pos=7, ring=3 → `out_char` == `in_char` each cycle, latency 1, `out_valid` 1 each cycle, `out_err` 0.
- **Swap-entry offset check:** write 0→4 and 4→0, leaving the rest identity; set pos=1, ring=0.
  - fwd in=25 → out=3.
  - rev in=3 → out=25.
  - fwd in=0 → out=0 (s=1, identity).
- **Stepping and turnover:**
  - pos_load 24, step ×3 → `pos_out` 25, 0, 1, with no carry.
  - pos_load 16, step → `pos_out` 17 and `carry_out` 1 for exactly one cycle.
  - pos_load and step together at pos 16 → load wins, no carry.
- **Simultaneous step and lookup:** with the swap table, pos=1, assert `step` with fwd in=25 in the same cycle → out=3 (old pos), and the next-cycle `pos_out`=2.
- **Range rejection:**
  - in=27 → `out_err` 1, `out_char` 31.
  - cfg write addr=26 → table unchanged.
  - pos_load 30 → pos unchanged.
  - ring_load 26 → ring unchanged.
- **Reset mid-stream:** stream 10 chars back-to-back and assert `rst` on the 5th → `out_valid` 0 next cycle, pos/ring 0, table identity.
